// File: rtl/dmem_arb_pkg.sv
// Shared types and address constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef logic mid_t;

  localparam mid_t M0 = 1'b0;
  localparam mid_t M1 = 1'b1;

  localparam logic [31:0] DMEM_BASE = 32'h0000_1000;
  localparam logic [31:0] DMEM_END  = 32'h0000_1800;
  localparam logic [31:0] PORTA     = 32'h0000_7f00;
  localparam logic [31:0] PORTB     = 32'h0000_7f10;
  localparam logic [31:0] PORTC     = 32'h0000_7f20;
  localparam logic [31:0] PORTD     = 32'h0000_7ffc;

endpackage

// File: rtl/dmem_arb_pick.sv
// Owner selection for simultaneous requests.
// DMEM_ARB_RR_EN selects round-robin; otherwise m0 has fixed priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  mid_t last,
  output logic valid,
  output mid_t sel
);

`ifndef DMEM_ARB_RR_EN
  logic last_unused;
  assign last_unused = last;
`endif

  always_comb begin
    valid = req0 | req1;
`ifdef DMEM_ARB_RR_EN
    if (req0 && req1) begin
      sel = (last == M0) ? M1 : M0;
    end else begin
      sel = req1 ? M1 : M0;
    end
`else
    sel = req0 ? M0 : M1;
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master burst arbiter for the single-port data memory / I/O block.
// Optional round-robin selection via DMEM_ARB_RR_EN (see dmem_arb_pick).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [LEN_W-1:0]  m0_len,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [LEN_W-1:0]  m1_len,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  cnt_q;
  mid_t              owner_q;
  mid_t              last_q;
  logic              we_q;
  logic              m0_gnt_q;
  logic              m1_gnt_q;

  logic              pick_valid;
  mid_t              pick_sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic              sel_we;
  logic              owner_req;
  logic [DATA_W-1:0] owner_wdata;
  logic              beat;

  dmem_arb_pick u_pick (
    .req0  (m0_req),
    .req1  (m1_req),
    .last  (last_q),
    .valid (pick_valid),
    .sel   (pick_sel)
  );

  // Beat outputs are combinational so an owner dropping req aborts in the same cycle.
  always_comb begin
    sel_addr    = (pick_sel == M1) ? m1_addr : m0_addr;
    sel_len     = (pick_sel == M1) ? m1_len  : m0_len;
    sel_we      = (pick_sel == M1) ? m1_we   : m0_we;
    owner_req   = (owner_q == M1) ? m1_req   : m0_req;
    owner_wdata = (owner_q == M1) ? m1_wdata : m0_wdata;
    beat        = (state_q == BUSY) && owner_req;
    mem_a       = addr_q;
    mem_we      = beat && we_q;
    mem_wd      = beat ? owner_wdata : '0;
    m0_ack      = beat && (owner_q == M0);
    m1_ack      = beat && (owner_q == M1);
    m0_rdata    = m0_ack ? mem_rd : '0;
    m1_rdata    = m1_ack ? mem_rd : '0;
  end

  assign m0_gnt = m0_gnt_q;
  assign m1_gnt = m1_gnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      owner_q  <= M0;
      last_q   <= M0;
      we_q     <= 1'b0;
      m0_gnt_q <= 1'b0;
      m1_gnt_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q  <= BUSY;
            owner_q  <= pick_sel;
            last_q   <= pick_sel;
            addr_q   <= sel_addr & ~ADDR_W'(3);
            cnt_q    <= sel_len;
            we_q     <= sel_we;
            m0_gnt_q <= (pick_sel == M0);
            m1_gnt_q <= (pick_sel == M1);
          end
        end
        BUSY: begin
          if (owner_req) begin
            addr_q <= addr_q + ADDR_W'(4);
            cnt_q  <= cnt_q - 1'b1;
          end
          if (!owner_req || (cnt_q == '0)) begin
            state_q  <= IDLE;
            m0_gnt_q <= 1'b0;
            m1_gnt_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
